// File: rtl/wdt_pkg.sv
// Shared types and register map for the watchdog host-side controller.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    ARMED   = 2'd2,
    TRIPPED = 2'd3
  } wdt_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LIVE   = 2'd1;
  localparam logic [1:0] REG_WTOCNT = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int STATUS_TO    = 0;
  localparam int STATUS_ERR   = 1;
  localparam int STATUS_ST_LO = 2;
  localparam int STATUS_ST_HI = 3;

  function automatic logic [31:0] status_word(wdt_state_e st, logic err, logic to);
    logic [31:0] w;
    w = '0;
    w[STATUS_TO] = to;
    w[STATUS_ERR] = err;
    w[STATUS_ST_HI:STATUS_ST_LO] = st;
    return w;
  endfunction

endpackage

// File: rtl/wdt_sync2.sv
// Two-flop synchroniser for a slow level from another clock domain, with a
// registered single-cycle pulse on each synchronised rising edge.
module wdt_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic sync1_q, sync2_q, pulse_q;
  logic sync1_d, sync2_d, pulse_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
    // Edge is taken where sync1 has settled high and sync2 has not yet followed.
    pulse_d = sync1_q & ~sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/wdt_host_ctrl.sv
// System-clock-side watchdog controller: register port, CDC-safe wden/wdlive/wtocnt
// drive and synchronised timeout status. Define WDT_HOST_LOCK_EN to lock out disables once armed.
module wdt_host_ctrl
  import wdt_pkg::*;
#(
  parameter int LIVE_STRETCH = 4,
  parameter int SETTLE_CYC   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  input  logic        wto_async,
  output logic        wden,
  output logic        wdlive,
  output logic [31:0] wtocnt,
  output logic        irq
);

  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int LCW = $clog2(LIVE_STRETCH + 1);

  wdt_state_e  state_q, state_d;
  logic [SCW-1:0] settle_q, settle_d;
  logic [LCW-1:0] stretch_q, stretch_d;
  logic        wdlive_q, wdlive_d;
  logic [31:0] wtocnt_q, wtocnt_d;
  logic        to_q, to_d;
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  logic wto_edge;
  logic wr, rd;
  logic to_set, to_clr, err_set, err_clr;
  logic wden_int;

  wdt_sync2 u_wto_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (wto_async),
    .pulse (wto_edge)
  );

  // ARMED and TRIPPED share state bit 1, so wden decodes from a single flop.
  assign wden_int = state_q[1];

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    stretch_d = stretch_q;
    wtocnt_d  = wtocnt_q;
    to_set    = 1'b0;
    to_clr    = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    wr        = req & we;
    rd        = req & ~we;

    if (state_q == SETTLE) begin
      if (settle_q <= SCW'(1)) begin
        settle_d = '0;
        state_d  = ARMED;
      end else begin
        settle_d = settle_q - SCW'(1);
      end
    end

    if (stretch_q != '0) stretch_d = stretch_q - LCW'(1);

    if (wto_edge) begin
      to_set = 1'b1;
      if (state_q == ARMED) state_d = TRIPPED;
    end

    if (wr) begin
      case (addr)
        REG_CTRL: begin
          if (wdata[0]) begin
            if (state_q == IDLE) begin
              state_d  = SETTLE;
              settle_d = SCW'(SETTLE_CYC);
            end
          end else begin
`ifdef WDT_HOST_LOCK_EN
            if (state_q == ARMED || state_q == TRIPPED) begin
              err_set = 1'b1;
            end else begin
              state_d   = IDLE;
              settle_d  = '0;
              stretch_d = '0;
            end
`else
            state_d   = IDLE;
            settle_d  = '0;
            stretch_d = '0;
`endif
          end
        end
        REG_LIVE: begin
          if (wdata[0]) begin
            if (state_q == ARMED) stretch_d = LCW'(LIVE_STRETCH);
            else err_set = 1'b1;
          end
        end
        REG_WTOCNT: begin
          if (state_q == IDLE) wtocnt_d = wdata;
          else err_set = 1'b1;
        end
        default: begin
          to_clr  = wdata[STATUS_TO];
          err_clr = wdata[STATUS_ERR];
        end
      endcase
    end

    // Set beats a same-cycle write-1-to-clear.
    to_d  = to_set  | (to_q  & ~to_clr);
    err_d = err_set | (err_q & ~err_clr);

    // wdlive gets its own flop so the crossing signal is glitch-free.
    wdlive_d = (stretch_d != '0);

    ack_d   = req;
    rdata_d = '0;
    if (rd) begin
      case (addr)
        REG_CTRL:   rdata_d = {31'b0, wden_int};
        REG_LIVE:   rdata_d = {31'b0, wdlive_q};
        REG_WTOCNT: rdata_d = wtocnt_q;
        default:    rdata_d = status_word(state_q, err_q, to_q);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      stretch_q <= '0;
      wdlive_q  <= 1'b0;
      wtocnt_q  <= '0;
      to_q      <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      stretch_q <= stretch_d;
      wdlive_q  <= wdlive_d;
      wtocnt_q  <= wtocnt_d;
      to_q      <= to_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign wden   = wden_int;
  assign wdlive = wdlive_q;
  assign wtocnt = wtocnt_q;
  assign irq    = to_q;
  assign ack    = ack_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_wdt_host_ctrl.sv
// Self-checking bench for wdt_host_ctrl: bus reads are scoreboarded, pin
// behaviour is checked against cycle-exact expectations.
module tb_wdt_host_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        wto_async;
  logic        wden;
  logic        wdlive;
  logic [31:0] wtocnt;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic        live_s[10];

  wdt_host_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .wto_async (wto_async),
    .wden      (wden),
    .wdlive    (wdlive),
    .wtocnt    (wtocnt),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every access expects rdata in its ack cycle; writes expect 0.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    exp_q.push_back(32'd0);
    $display("wr  addr=%0d data=0x%0h", a, d);
    tick();
    req = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
    req = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(exp);
    $display("rd  addr=%0d expect=0x%0h", a, exp);
    tick();
    req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ack) begin
      if (exp_q.size() == 0) check_eq("ack_unexpected", 32'd1, 32'd0);
      else check_eq("rdata", rdata, exp_q.pop_front());
    end else begin
      check_eq("rdata_idle", rdata, 32'd0);
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wto_async = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_wden", 32'(wden), 32'd0);
    check_eq("rst_wdlive", 32'(wdlive), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_wtocnt", wtocnt, 32'd0);
    bus_read(2'd3, 32'd0);

    // Kick while IDLE is an error and must not pulse wdlive.
    bus_write(2'd1, 32'd1);
    check_eq("idle_kick_wdlive", 32'(wdlive), 32'd0);
    bus_read(2'd3, 32'd2);
    bus_write(2'd3, 32'd2);
    bus_read(2'd3, 32'd0);

    bus_write(2'd2, 32'd1000);
    check_eq("wtocnt_load", wtocnt, 32'd1000);
    bus_read(2'd2, 32'd1000);

    bus_write(2'd0, 32'd1);
    check_eq("arm_wden_0", 32'(wden), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("arm_wden", 32'(wden), 32'(k == 8));
    end
    bus_read(2'd3, 32'd8);
    bus_read(2'd0, 32'd1);

    // Two kicks two cycles apart: one contiguous 6-cycle wdlive pulse.
    bus_write(2'd1, 32'd1);
    live_s[0] = wdlive;
    tick();
    live_s[1] = wdlive;
    bus_write(2'd1, 32'd1);
    live_s[2] = wdlive;
    for (int i = 3; i < 10; i++) begin
      tick();
      live_s[i] = wdlive;
    end
    for (int i = 0; i < 10; i++) check_eq("kick_wdlive", 32'(live_s[i]), 32'(i < 6));

    bus_write(2'd2, 32'd5);
    check_eq("wtocnt_protect", wtocnt, 32'd1000);
    bus_read(2'd3, 32'd10);
    bus_write(2'd3, 32'd2);
    bus_read(2'd3, 32'd8);

`ifdef WDT_HOST_LOCK_EN
    bus_write(2'd0, 32'd0);
    check_eq("lock_wden", 32'(wden), 32'd1);
    bus_read(2'd3, 32'd10);
    bus_write(2'd3, 32'd2);
    bus_read(2'd3, 32'd8);
`else
    bus_write(2'd1, 32'd1);
    check_eq("pre_dis_wdlive", 32'(wdlive), 32'd1);
    bus_write(2'd0, 32'd0);
    check_eq("dis_wden", 32'(wden), 32'd0);
    check_eq("dis_wdlive", 32'(wdlive), 32'd0);
    bus_read(2'd3, 32'd0);
    bus_write(2'd0, 32'd1);
    repeat (8) tick();
    check_eq("rearm_wden", 32'(wden), 32'd1);
    bus_read(2'd3, 32'd8);
`endif

    // Timeout: irq three edges after wto_async rises.
    wto_async = 1'b1;
    tick();
    check_eq("to_irq_e0", 32'(irq), 32'd0);
    tick();
    check_eq("to_irq_e1", 32'(irq), 32'd0);
    tick();
    check_eq("to_irq_e2", 32'(irq), 32'd1);
    check_eq("to_wden", 32'(wden), 32'd1);
    bus_read(2'd3, 32'd13);
    bus_write(2'd1, 32'd1);
    check_eq("tripped_kick_wdlive", 32'(wdlive), 32'd0);
    bus_read(2'd3, 32'd15);

    // W1C of TO colliding with a fresh edge: set wins.
    bus_write(2'd3, 32'd3);
    check_eq("w1c_irq", 32'(irq), 32'd0);
    wto_async = 1'b0;
    repeat (4) tick();
    wto_async = 1'b1;
    tick();
    tick();
    bus_write(2'd3, 32'd1);
    check_eq("w1c_vs_set_irq", 32'(irq), 32'd1);
    bus_read(2'd3, 32'd13);
    bus_write(2'd3, 32'd1);
    check_eq("w1c_after_irq", 32'(irq), 32'd0);
    wto_async = 1'b0;

    // Reset mid-operation, including a wdlive pulse in flight.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_wden", 32'(wden), 32'd0);
    check_eq("rst2_irq", 32'(irq), 32'd0);
    check_eq("rst2_wtocnt", wtocnt, 32'd0);
    bus_read(2'd3, 32'd0);
    bus_write(2'd0, 32'd1);
    repeat (8) tick();
    bus_write(2'd1, 32'd1);
    tick();
    check_eq("inflight_wdlive", 32'(wdlive), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("rst3_wdlive", 32'(wdlive), 32'd0);
    check_eq("rst3_wden", 32'(wden), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
